// File: rtl/button_debouncer_multi_debounce_channel.sv
// One button: 2-flop sync, symmetric debounce, press/release/long-press strobes.
// Latency: STABLE_CYCLES+2 edges from pin change to state. No backpressure.
module debounce_channel #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int HOLD_CYCLES   = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic state_o,
  output logic pressed_o,
  output logic released_o,
  output logic long_press_o
);
  localparam int DB_W = $clog2(STABLE_CYCLES);
  localparam int HD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

  logic            s0_q, s0_d, s1_q, s1_d;
  logic            state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic [HD_W-1:0] hcnt_q, hcnt_d;
  logic            long_done_q, long_done_d;
  logic            pressed_q, pressed_d;
  logic            released_q, released_d;
  logic            long_press_q, long_press_d;

  always_comb begin
    s0_d    = btn_i;
    s1_d    = s0_q;
    state_d = state_q;
    cnt_d   = '0;
    // Any agreeing sample leaves cnt_d at zero, restarting the window.
    if (s1_q != state_q) begin
      if (cnt_q == DB_LAST) begin
        state_d = s1_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
    pressed_d  = state_d & ~state_q;
    released_d = ~state_d & state_q;

    hcnt_d       = hcnt_q;
    long_done_d  = long_done_q;
    long_press_d = 1'b0;
    if (!state_q) begin
      hcnt_d      = '0;
      long_done_d = 1'b0;
    end else if (!long_done_q) begin
      if (hcnt_q == HD_LAST) begin
        long_done_d  = 1'b1;
        long_press_d = ~released_d;  // a release on the firing edge wins
      end else begin
        hcnt_d = hcnt_q + HD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      state_q      <= 1'b0;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      long_done_q  <= 1'b0;
      pressed_q    <= 1'b0;
      released_q   <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      long_done_q  <= long_done_d;
      pressed_q    <= pressed_d;
      released_q   <= released_d;
      long_press_q <= long_press_d;
    end
  end

  assign state_o      = state_q;
  assign pressed_o    = pressed_q;
  assign released_o   = released_q;
  assign long_press_o = long_press_q;
endmodule

// File: rtl/button_debouncer_multi.sv
// CHANNELS independent debounced buttons with optional active-low pins.
// Latency: STABLE_CYCLES+2 edges pin-to-state, all outputs registered. No backpressure.
module button_debouncer_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] state,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] long_press
);
  logic [CHANNELS-1:0] b;

  // Normalise so that 1 always means pressed from the synchroniser onwards.
  assign b = (ACTIVE_LOW != 0) ? ~btn : btn;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_i       (b[i]),
      .state_o     (state[i]),
      .pressed_o   (pressed[i]),
      .released_o  (released[i]),
      .long_press_o(long_press[i])
    );
  end
endmodule

// File: tb/tb_button_debouncer_multi.sv
// Directed bench: per-cycle expected outputs queued at drive time, checked after each edge.
module tb_button_debouncer_multi;
  logic       clk;
  logic       rst_n, rst_al_n;
  logic [1:0] btn, btn_al;
  logic [1:0] st, pr, rl, lp;
  logic [1:0] st_a, pr_a, rl_a, lp_a;

  button_debouncer_multi #(.CHANNELS(2), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .state(st), .pressed(pr), .released(rl), .long_press(lp)
  );

  button_debouncer_multi #(.CHANNELS(2), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_al_n), .btn(btn_al),
    .state(st_a), .pressed(pr_a), .released(rl_a), .long_press(lp_a)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected levels/strobes; strobes are cleared automatically after each cycle.
  logic [1:0] es, ep, er, el;
  logic [1:0] xs, xp, xr, xl;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  int total = 0;
  int bad   = 0;

  task automatic cyc(input string tag);
    logic [15:0] e;
    logic [15:0] obs;
    string       t;
    exp_q.push_back({xs, xp, xr, xl, es, ep, er, el});
    tag_q.push_back(tag);
    ep = 2'b00; er = 2'b00; el = 2'b00;
    xp = 2'b00; xr = 2'b00; xl = 2'b00;
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = {st_a, pr_a, rl_a, lp_a, st, pr, rl, lp};
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (al:st,pr,rl,lp | main:st,pr,rl,lp)", t, obs, e);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    es = 0; ep = 0; er = 0; el = 0;
    xs = 0; xp = 0; xr = 0; xl = 0;
    rst_n = 1'b0; rst_al_n = 1'b0;
    btn = 2'b11; btn_al = 2'b11;

    // 1. reset, then re-debounce of a held level
    run(3, "t1_rst");
    rst_n = 1'b1;
    run(5, "t1_wait");
    es = 2'b11; ep = 2'b11; cyc("t1_press");
    run(9, "t1_hold");
    el = 2'b11; cyc("t1_long");
    run(4, "t1_nolong");
    btn = 2'b00;
    run(5, "t1_relwait");
    es = 2'b00; er = 2'b11; cyc("t1_release");
    run(2, "t1_idle");

    // 2. bursts shorter than the window are rejected
    for (int r = 0; r < 3; r++) begin
      btn = 2'b01; cyc("t2_bounce");
      btn = 2'b01; cyc("t2_bounce");
      btn = 2'b01; cyc("t2_bounce");
      btn = 2'b00; cyc("t2_bounce");
    end
    btn = 2'b01;
    run(5, "t2_wait");
    es = 2'b01; ep = 2'b01; cyc("t2_press");

    // 3. short release dip ignored; long press still counted from the rise
    run(3, "t3_hold");
    btn = 2'b00;
    run(3, "t3_dip");
    btn = 2'b01;
    run(3, "t3_back");
    el = 2'b01; cyc("t3_long0");
    run(3, "t3_nolong");
    btn = 2'b00;
    run(5, "t3_relwait");
    es = 2'b00; er = 2'b01; cyc("t3_release");
    run(2, "t3_idle");

    // 4. long press on ch1, once per press, again after re-press
    btn = 2'b10;
    run(5, "t4_wait");
    es = 2'b10; ep = 2'b10; cyc("t4_press");
    run(9, "t4_hold");
    el = 2'b10; cyc("t4_long");
    run(6, "t4_noreplay");
    btn = 2'b00;
    run(5, "t4_relwait");
    es = 2'b00; er = 2'b10; cyc("t4_release");
    btn = 2'b10;
    run(5, "t4_rewait");
    es = 2'b10; ep = 2'b10; cyc("t4_repress");
    run(9, "t4_rehold");
    el = 2'b10; cyc("t4_long_again");
    btn = 2'b00;
    run(5, "t4_relwait2");
    es = 2'b00; er = 2'b10; cyc("t4_release2");

    // release landing on the long-press edge suppresses long_press
    btn = 2'b10;
    run(5, "t4w_wait");
    es = 2'b10; ep = 2'b10; cyc("t4w_press");
    run(4, "t4w_hold");
    btn = 2'b00;
    run(5, "t4w_relwait");
    es = 2'b00; er = 2'b10; cyc("t4w_release_wins");
    run(3, "t4w_nolong");

    // 5. simultaneous press ch0 / release ch1
    btn = 2'b10;
    run(5, "t5_wait");
    es = 2'b10; ep = 2'b10; cyc("t5_press1");
    run(9, "t5_hold");
    el = 2'b10; cyc("t5_long1");
    run(2, "t5_settle");
    btn = 2'b01;
    run(5, "t5_flipwait");
    es = 2'b01; ep = 2'b01; er = 2'b10; cyc("t5_simul");
    run(2, "t5_after");
    btn = 2'b00;
    run(5, "t5_relwait");
    es = 2'b00; er = 2'b01; cyc("t5_release0");

    // 6. active-low instance, reset mid-hold
    rst_al_n = 1'b1;
    run(8, "t6_idle");
    btn_al = 2'b10;
    run(5, "t6_wait");
    xs = 2'b01; xp = 2'b01; cyc("t6_press");
    run(4, "t6_hold");
    rst_al_n = 1'b0;
    xs = 2'b00; cyc("t6_rst_clear");
    rst_al_n = 1'b1;
    run(5, "t6_no_long");
    xs = 2'b01; xp = 2'b01; cyc("t6_repress");
    run(3, "t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
